// File: rtl/objram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : objram_pkg
//  Description : Shared types for the double-buffered object RAM: DMA state
//                encoding, column-count helper and a packed object entry.
//  Revision    : 1.0 - initial release
// ============================================================================
package objram_pkg;

  // Default object entry geometry (16-bit words per entry)
  localparam int DEF_COLS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    XFER  = 2'd2
  } dma_state_t;

  // Column-select width for a power-of-two column count
  function automatic int col_bits(input int cols);
    return $clog2(cols);
  endfunction

  // One object entry, column 0 in the low 16 bits
  typedef struct packed {
    logic [DEF_COLS-1:0][15:0] w;
  } entry_t;

endpackage
`default_nettype wire

// File: rtl/objram_bank.sv
`default_nettype none
// ============================================================================
//  Module      : objram_bank
//  Description : Simple dual-port wide RAM. Port A: read/write with byte
//                enables; port B: read only. Both reads are registered and
//                return the contents before any same-cycle write (read-old).
//  Ports       : clk, reset_n        clock / async active-low reset (read regs)
//                a_addr_i/a_we_i/a_be_i/a_d_i/a_q_o   port A
//                b_addr_i/b_q_o                        port B
//  Revision    : 1.0 - initial release
// ============================================================================
module objram_bank #(
  parameter int ENT_W = 9,
  parameter int Q_W   = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [ENT_W-1:0] a_addr_i,
  input  logic             a_we_i,
  input  logic [Q_W/8-1:0] a_be_i,
  input  logic [Q_W-1:0]   a_d_i,
  output logic [Q_W-1:0]   a_q_o,
  input  logic [ENT_W-1:0] b_addr_i,
  output logic [Q_W-1:0]   b_q_o
);

  localparam int NB    = Q_W / 8;
  localparam int DEPTH = 2 ** ENT_W;

  logic [Q_W-1:0] mem [DEPTH];
  logic [Q_W-1:0] a_q_q;
  logic [Q_W-1:0] b_q_q;

  // Storage array carries no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (a_we_i) begin
      for (int b = 0; b < NB; b++) begin
        if (a_be_i[b]) begin
          mem[a_addr_i][8*b +: 8] <= a_d_i[8*b +: 8];
        end
      end
    end
  end

  // Non-blocking reads of the array give old data on a same-cycle write
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q_q <= '0;
      b_q_q <= '0;
    end else begin
      a_q_q <= mem[a_addr_i];
      b_q_q <= mem[b_addr_i];
    end
  end

  assign a_q_o = a_q_q;
  assign b_q_o = b_q_q;

endmodule
`default_nettype wire

// File: rtl/objram_dbuf.sv
`default_nettype none
// ============================================================================
//  Module      : objram_dbuf
//  Description : Double-buffered object RAM. CPU reads/writes 16-bit words of
//                the work bank; a DMA copies (or zero-fills) work -> display
//                one entry per clock; the sprite engine reads whole display
//                entries.
//  Ports       : clk, reset_n                     clock / async active-low reset
//                cpu_addr/cpu_we/cpu_be/cpu_data  CPU write, cpu_q read (1-cycle)
//                dma_start/dma_fill               transfer request / fill mode
//                dma_busy/dma_done                transfer status
//                obj_addr/obj_q                   display entry read (1-cycle)
//  Revision    : 1.0 - initial release
// ============================================================================
module objram_dbuf
  import objram_pkg::*;
#(
  parameter  int ADDR_W = 11,
  parameter  int COLS   = 4,
  localparam int COL_W  = col_bits(COLS),
  localparam int ENT_W  = ADDR_W - COL_W,
  localparam int Q_W    = 16 * COLS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_we,
  input  logic [1:0]        cpu_be,
  input  logic [15:0]       cpu_data,
  output logic [15:0]       cpu_q,
  input  logic              dma_start,
  input  logic              dma_fill,
  output logic              dma_busy,
  output logic              dma_done,
  input  logic [ENT_W-1:0]  obj_addr,
  output logic [Q_W-1:0]    obj_q
);

  localparam int DEPTH = 2 ** ENT_W;
  localparam int CNT_W = ENT_W + 1;

  dma_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fill_q, fill_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [COL_W-1:0] col_sel_q;

  logic [Q_W/8-1:0] w_cpu_be;
  logic [Q_W-1:0]   w_cpu_d;
  logic [Q_W-1:0]   w_work_a_q;
  logic [Q_W-1:0]   w_work_b_q;
  logic [15:0]      w_cpu_words [COLS];
  logic [ENT_W-1:0] w_rd_addr;
  logic             w_disp_we;
  logic [Q_W-1:0]   w_disp_d;
  logic [Q_W-1:0]   unused_disp_a_q;

  // Steer the 16-bit CPU write into its column of the wide entry
  for (genvar c = 0; c < COLS; c++) begin : g_col
    assign w_cpu_be[2*c +: 2]  = (cpu_addr[COL_W-1:0] == COL_W'(c)) ? cpu_be : 2'b00;
    assign w_cpu_d[16*c +: 16] = cpu_data;
    assign w_cpu_words[c]      = w_work_a_q[16*c +: 16];
  end

  // Column select follows the registered RAM output
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) col_sel_q <= '0;
    else          col_sel_q <= cpu_addr[COL_W-1:0];
  end

  assign cpu_q = w_cpu_words[col_sel_q];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fill_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fill_d    = fill_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    w_rd_addr = cnt_q[ENT_W-1:0];
    w_disp_we = 1'b0;
    case (state_q)
      IDLE: begin
        if (dma_start) begin
          fill_d  = dma_fill;
          cnt_d   = '0;
          busy_d  = 1'b1;
          // A fill needs no read-ahead, so it skips the priming cycle
          state_d = dma_fill ? XFER : PRIME;
        end
      end
      PRIME: begin
        state_d = XFER;
      end
      XFER: begin
        w_disp_we = 1'b1;
        // Read one entry ahead so the next write has its data ready
        w_rd_addr = cnt_q[ENT_W-1:0] + ENT_W'(1);
        if (cnt_q == CNT_W'(DEPTH - 1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign w_disp_d = fill_q ? '0 : w_work_b_q;
  assign dma_busy = busy_q;
  assign dma_done = done_q;

  objram_bank #(
    .ENT_W (ENT_W),
    .Q_W   (Q_W)
  ) u_work (
    .clk      (clk),
    .reset_n  (reset_n),
    .a_addr_i (cpu_addr[ADDR_W-1:COL_W]),
    .a_we_i   (cpu_we),
    .a_be_i   (w_cpu_be),
    .a_d_i    (w_cpu_d),
    .a_q_o    (w_work_a_q),
    .b_addr_i (w_rd_addr),
    .b_q_o    (w_work_b_q)
  );

  objram_bank #(
    .ENT_W (ENT_W),
    .Q_W   (Q_W)
  ) u_disp (
    .clk      (clk),
    .reset_n  (reset_n),
    .a_addr_i (cnt_q[ENT_W-1:0]),
    .a_we_i   (w_disp_we),
    .a_be_i   ({(Q_W/8){1'b1}}),
    .a_d_i    (w_disp_d),
    .a_q_o    (unused_disp_a_q),
    .b_addr_i (obj_addr),
    .b_q_o    (obj_q)
  );

endmodule
`default_nettype wire

// File: tb/tb_objram_dbuf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_objram_dbuf
//  Description : Self-checking bench for objram_dbuf (ADDR_W=11, COLS=4).
//                Expected read data is queued when an address is driven and
//                compared when the registered output appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_objram_dbuf;
  import objram_pkg::*;

  localparam int ADDR_W = 11;
  localparam int COLS   = 4;
  localparam int ENT_W  = 9;
  localparam int DEPTH  = 512;
  localparam int Q_W    = 64;
  localparam int WORDS  = 2048;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic              cpu_we = 1'b0;
  logic [1:0]        cpu_be = 2'b00;
  logic [15:0]       cpu_data = '0;
  logic [15:0]       cpu_q;
  logic              dma_start = 1'b0;
  logic              dma_fill = 1'b0;
  logic              dma_busy;
  logic              dma_done;
  logic [ENT_W-1:0]  obj_addr = '0;
  logic [Q_W-1:0]    obj_q;

  always #5 clk = ~clk;

  objram_dbuf #(.ADDR_W(ADDR_W), .COLS(COLS)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cpu_addr  (cpu_addr),
    .cpu_we    (cpu_we),
    .cpu_be    (cpu_be),
    .cpu_data  (cpu_data),
    .cpu_q     (cpu_q),
    .dma_start (dma_start),
    .dma_fill  (dma_fill),
    .dma_busy  (dma_busy),
    .dma_done  (dma_done),
    .obj_addr  (obj_addr),
    .obj_q     (obj_q)
  );

  typedef struct packed {
    logic [31:0]    tag;
    logic [Q_W-1:0] exp;
  } sb_t;

  sb_t         cpu_sb[$];
  sb_t         obj_sb[$];
  logic [15:0] work_m [WORDS];
  logic [Q_W-1:0] disp_m [DEPTH];
  int checks = 0;
  int errors = 0;

  // Work-bank entry as held by the model
  function automatic logic [Q_W-1:0] model_entry(input int e);
    entry_t t;
    for (int c = 0; c < COLS; c++) t.w[c] = work_m[e*COLS + c];
    return t;
  endfunction

  task automatic cpu_write(input int a, input logic [15:0] d, input logic [1:0] be);
    @(negedge clk);
    cpu_addr = ADDR_W'(a);
    cpu_data = d;
    cpu_be   = be;
    cpu_we   = 1'b1;
    if (be[0]) work_m[a][7:0]  = d[7:0];
    if (be[1]) work_m[a][15:8] = d[15:8];
    @(posedge clk);
    #1 cpu_we = 1'b0;
  endtask

  // Pulses dma_start and measures busy/done; optional second pulse mid-run
  task automatic run_dma(input logic fill, input int second_at,
                         output int busy_cnt, output int done_cnt, output bit timeout);
    @(negedge clk);
    dma_fill  = fill;
    dma_start = 1'b1;
    @(negedge clk);
    dma_start = 1'b0;
    busy_cnt  = 0;
    done_cnt  = 0;
    timeout   = 1'b1;
    for (int cyc = 0; cyc < 4*DEPTH; cyc++) begin
      if (dma_busy) busy_cnt++;
      if (dma_done) done_cnt++;
      dma_start = (cyc == second_at);
      if (!dma_busy && !dma_done && busy_cnt > 0 && done_cnt > 0) begin
        timeout = 1'b0;
        break;
      end
      @(negedge clk);
    end
    dma_start = 1'b0;
    dma_fill  = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (dma_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", dma_busy); end
    checks++; if (dma_done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", dma_done); end
    checks++; if (cpu_q !== 16'h0) begin errors++; $display("FAIL reset_cpu_q got=%h exp=0000", cpu_q); end
    checks++; if (obj_q !== '0) begin errors++; $display("FAIL reset_obj_q got=%h exp=0", obj_q); end
    reset_n = 1'b1;
  endtask

  task automatic test_cpu_write();
    sb_t s;
    cpu_write(4, 16'h4444, 2'b11);
    cpu_write(5, 16'h5555, 2'b11);
    cpu_write(6, 16'h6666, 2'b11);
    cpu_write(7, 16'h7777, 2'b11);
    cpu_write(5, 16'h1234, 2'b11);
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (cpu_sb.size() > 0) begin
        s = cpu_sb.pop_front();
        checks++;
        if (cpu_q !== s.exp[15:0]) begin
          errors++;
          $display("FAIL cpu_word addr=%0d got=%h exp=%h", s.tag, cpu_q, s.exp[15:0]);
        end
      end
      if (i < 4) begin
        cpu_addr = ADDR_W'(4 + i);
        s.tag = 32'(4 + i);
        s.exp = Q_W'((i == 1) ? 16'h1234 : {4{4'(4 + i)}});
        cpu_sb.push_back(s);
      end
    end
  endtask

  task automatic test_byte_enables();
    sb_t s;
    cpu_write(9, 16'hFFFF, 2'b11);
    cpu_write(9, 16'h00AB, 2'b01);
    @(negedge clk);
    cpu_addr = ADDR_W'(9);
    s.tag = 32'd9; s.exp = Q_W'(16'hFFAB); cpu_sb.push_back(s);
    @(negedge clk);
    s = cpu_sb.pop_front();
    checks++;
    if (cpu_q !== s.exp[15:0]) begin errors++; $display("FAIL be_low got=%h exp=%h", cpu_q, s.exp[15:0]); end
    cpu_write(9, 16'hCD00, 2'b10);
    @(negedge clk);
    cpu_addr = ADDR_W'(9);
    s.tag = 32'd9; s.exp = Q_W'(16'hCDAB); cpu_sb.push_back(s);
    @(negedge clk);
    s = cpu_sb.pop_front();
    checks++;
    if (cpu_q !== s.exp[15:0]) begin errors++; $display("FAIL be_high got=%h exp=%h", cpu_q, s.exp[15:0]); end
  endtask

  task automatic test_copy();
    int busy_c, done_c;
    bit to;
    sb_t s;
    int lst[4] = '{3, 0, 200, 511};
    for (int a = 0; a < WORDS; a++) cpu_write(a, 16'(a), 2'b11);
    run_dma(1'b0, -1, busy_c, done_c, to);
    checks++; if (to) begin errors++; $display("FAIL copy_timeout got=no_done exp=done"); end
    checks++; if (busy_c != DEPTH + 1) begin errors++; $display("FAIL copy_busy got=%0d exp=%0d", busy_c, DEPTH + 1); end
    checks++; if (done_c != 1) begin errors++; $display("FAIL copy_done got=%0d exp=1", done_c); end
    for (int e = 0; e < DEPTH; e++) disp_m[e] = model_entry(e);
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (obj_sb.size() > 0) begin
        s = obj_sb.pop_front();
        checks++;
        if (obj_q !== s.exp) begin errors++; $display("FAIL copy_entry e=%0d got=%h exp=%h", s.tag, obj_q, s.exp); end
      end
      if (i < 4) begin
        obj_addr = ENT_W'(lst[i]);
        s.tag = 32'(lst[i]);
        s.exp = (lst[i] == 3) ? 64'h000F_000E_000D_000C : disp_m[lst[i]];
        obj_sb.push_back(s);
      end
    end
  endtask

  task automatic test_fill();
    int busy_c, done_c;
    bit to;
    sb_t s;
    run_dma(1'b1, 60, busy_c, done_c, to);
    checks++; if (to) begin errors++; $display("FAIL fill_timeout got=no_done exp=done"); end
    checks++; if (busy_c != DEPTH) begin errors++; $display("FAIL fill_busy got=%0d exp=%0d", busy_c, DEPTH); end
    checks++; if (done_c != 1) begin errors++; $display("FAIL fill_done got=%0d exp=1", done_c); end
    // A second start mid-run must not have re-triggered anything afterwards
    repeat (4) @(negedge clk);
    checks++; if (dma_busy !== 1'b0) begin errors++; $display("FAIL fill_requeue got=%b exp=0", dma_busy); end
    for (int e = 0; e < DEPTH; e++) disp_m[e] = '0;
    for (int i = 0; i <= DEPTH; i++) begin
      @(negedge clk);
      if (obj_sb.size() > 0) begin
        s = obj_sb.pop_front();
        checks++;
        if (obj_q !== s.exp) begin errors++; $display("FAIL fill_entry e=%0d got=%h exp=%h", s.tag, obj_q, s.exp); end
      end
      if (i < DEPTH) begin
        obj_addr = ENT_W'(i);
        s.tag = 32'(i);
        s.exp = '0;
        obj_sb.push_back(s);
      end
    end
  endtask

  task automatic test_copy_cpu_race();
    int busy_c, done_c;
    bit to;
    sb_t s;
    int lst[2] = '{0, DEPTH - 1};
    for (int e = 0; e < DEPTH; e++) disp_m[e] = model_entry(e);
    fork
      run_dma(1'b0, -1, busy_c, done_c, to);
      begin
        repeat (12) @(negedge clk);
        cpu_write(0, 16'hBEEF, 2'b11);
        cpu_write((DEPTH - 1)*COLS + 2, 16'hBEEF, 2'b11);
      end
    join
    // Entry 0 was copied before the write; the last entry was not yet
    disp_m[DEPTH-1] = model_entry(DEPTH - 1);
    checks++; if (to) begin errors++; $display("FAIL race_timeout got=no_done exp=done"); end
    checks++; if (busy_c != DEPTH + 1) begin errors++; $display("FAIL race_busy got=%0d exp=%0d", busy_c, DEPTH + 1); end
    for (int i = 0; i <= 2; i++) begin
      @(negedge clk);
      if (obj_sb.size() > 0) begin
        s = obj_sb.pop_front();
        checks++;
        if (obj_q !== s.exp) begin errors++; $display("FAIL race_entry e=%0d got=%h exp=%h", s.tag, obj_q, s.exp); end
        if (s.tag == 32'(DEPTH - 1)) begin
          checks++;
          if (obj_q[47:32] !== 16'hBEEF) begin errors++; $display("FAIL race_col2 got=%h exp=beef", obj_q[47:32]); end
        end
      end
      if (i < 2) begin
        obj_addr = ENT_W'(lst[i]);
        s.tag = 32'(lst[i]);
        s.exp = disp_m[lst[i]];
        obj_sb.push_back(s);
      end
    end
  endtask

  task automatic test_reset_mid_copy();
    int busy_c, done_c;
    bit to;
    sb_t s;
    int lst[6] = '{0, 99, 100, 101, 511, 250};
    for (int a = 0; a < WORDS; a++) cpu_write(a, 16'(a) ^ 16'h5A5A, 2'b11);
    @(negedge clk);
    dma_fill  = 1'b0;
    dma_start = 1'b1;
    @(negedge clk);
    dma_start = 1'b0;
    // Entries 0..99 have been written when the counter reaches 100
    repeat (101) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++; if (dma_busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", dma_busy); end
    checks++; if (dma_done !== 1'b0) begin errors++; $display("FAIL abort_done got=%b exp=0", dma_done); end
    @(negedge clk);
    reset_n = 1'b1;
    for (int e = 0; e < 100; e++) disp_m[e] = model_entry(e);
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      if (obj_sb.size() > 0) begin
        s = obj_sb.pop_front();
        checks++;
        if (obj_q !== s.exp) begin errors++; $display("FAIL abort_entry e=%0d got=%h exp=%h", s.tag, obj_q, s.exp); end
      end
      if (i < 6) begin
        obj_addr = ENT_W'(lst[i]);
        s.tag = 32'(lst[i]);
        s.exp = disp_m[lst[i]];
        obj_sb.push_back(s);
      end
    end
    run_dma(1'b0, -1, busy_c, done_c, to);
    checks++; if (to) begin errors++; $display("FAIL rerun_timeout got=no_done exp=done"); end
    checks++; if (busy_c != DEPTH + 1) begin errors++; $display("FAIL rerun_busy got=%0d exp=%0d", busy_c, DEPTH + 1); end
    checks++; if (done_c != 1) begin errors++; $display("FAIL rerun_done got=%0d exp=1", done_c); end
    for (int e = 0; e < DEPTH; e++) disp_m[e] = model_entry(e);
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      if (obj_sb.size() > 0) begin
        s = obj_sb.pop_front();
        checks++;
        if (obj_q !== s.exp) begin errors++; $display("FAIL rerun_entry e=%0d got=%h exp=%h", s.tag, obj_q, s.exp); end
      end
      if (i < 6) begin
        obj_addr = ENT_W'(lst[i]);
        s.tag = 32'(lst[i]);
        s.exp = disp_m[lst[i]];
        obj_sb.push_back(s);
      end
    end
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_byte_enables();
    test_copy();
    test_fill();
    test_copy_cpu_race();
    test_reset_mid_copy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
